// File: rtl/uart_alu_pkg.sv
// Shared types for the UART ALU packet responder.
// Opcodes, FSM states and header geometry.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OPC_ADD  = 8'h01,
        OPC_ECHO = 8'hEC
    } opcode_e;

    typedef enum logic [3:0] {
        HDR_OP,
        HDR_RSVD,
        HDR_LEN_LO,
        HDR_LEN_HI,
        PAYLOAD_ADD,
        PAYLOAD_ECHO,
        ECHO_DRAIN,
        RESULT,
        DISCARD
    } state_e;

    localparam int HDR_BYTES = 4;

    // Packet length includes the header; short lengths carry no payload.
    function automatic logic [15:0] payload_count(input logic [15:0] len);
        return (len < 16'(HDR_BYTES)) ? 16'd0 : len - 16'(HDR_BYTES);
    endfunction

endpackage

// File: rtl/uart_alu_packet_engine_serializer.sv
// Holds a result word and hands it out one byte at a time, LSB first.
// The top owns the output register and pulls bytes via take_i.
module uart_alu_result_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             take_i,
    output logic [7:0]       byte_o,
    output logic             more_o
);

    localparam int NB    = WIDTH / 8;
    localparam int CNT_W = $clog2(NB + 1);

    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] left_q, left_d;

    always_comb begin
        word_d = word_q;
        left_d = left_q;
        if (load_i) begin
            word_d = word_i;
            left_d = CNT_W'(NB);
        end else if (take_i && left_q != '0) begin
            word_d = word_q >> 8;
            left_d = left_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_q <= '0;
            left_q <= '0;
        end else begin
            word_q <= word_d;
            left_q <= left_d;
        end
    end

    assign byte_o = word_q[7:0];
    assign more_o = (left_q != '0);

endmodule

// File: rtl/uart_alu_packet_engine.sv
// Responder for the UART ALU packet protocol: header parse, ADD, ECHO.
// Output register is shared by the echo path and the result serializer.
module uart_alu_packet_engine
    import uart_alu_pkg::*;
#(
    parameter logic [7:0] OPCODE_ADD  = OPC_ADD,
    parameter logic [7:0] OPCODE_ECHO = OPC_ECHO,
    parameter int         ACC_WIDTH   = 32
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       busy_o,
    output logic       bad_opcode_o
);

    localparam int ACC_BYTES = ACC_WIDTH / 8;
    localparam int LANE_W    = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(ACC_BYTES - 1);

    state_e               state_q, state_d;
    logic [7:0]           opc_q, opc_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [15:0]          rem_q, rem_d, pay_cnt;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [ACC_WIDTH-1:0] opnd_q, opnd_d, opnd_n;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 bad_q, bad_d;
    logic                 s_ready, in_fire, out_fire;
    logic                 last_pay, is_add, is_echo;
    logic                 ser_load, ser_take, ser_more;
    logic [7:0]           ser_byte;

    assign in_fire  = s_axis_tvalid_i && s_ready;
    assign out_fire = tvalid_q && m_axis_tready_i;
    assign last_pay = (rem_q == 16'd1);
    assign is_add   = (opc_q == OPCODE_ADD);
    assign is_echo  = (opc_q == OPCODE_ECHO);
    assign pay_cnt  = payload_count({s_axis_tdata_i, len_lo_q});

    uart_alu_result_serializer #(
        .WIDTH (ACC_WIDTH)
    ) u_ser (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (ser_load),
        .word_i  (acc_d),
        .take_i  (ser_take),
        .byte_o  (ser_byte),
        .more_o  (ser_more)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= HDR_OP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_OP:     if (in_fire) state_d = HDR_RSVD;
            HDR_RSVD:   if (in_fire) state_d = HDR_LEN_LO;
            HDR_LEN_LO: if (in_fire) state_d = HDR_LEN_HI;
            HDR_LEN_HI: begin
                if (in_fire) begin
                    if (is_add) begin
                        state_d = (pay_cnt != '0) ? PAYLOAD_ADD : RESULT;
                    end else if (is_echo) begin
                        state_d = (pay_cnt != '0) ? PAYLOAD_ECHO : HDR_OP;
                    end else begin
                        state_d = (pay_cnt != '0) ? DISCARD : HDR_OP;
                    end
                end
            end
            PAYLOAD_ADD:  if (in_fire && last_pay) state_d = RESULT;
            PAYLOAD_ECHO: if (in_fire && last_pay) state_d = ECHO_DRAIN;
            ECHO_DRAIN:   if (out_fire) state_d = HDR_OP;
            RESULT:       if (!ser_more && out_fire) state_d = HDR_OP;
            DISCARD:      if (in_fire && last_pay) state_d = HDR_OP;
            default:      state_d = HDR_OP;
        endcase
    end

    always_comb begin
        case (state_q)
            PAYLOAD_ECHO:       s_ready = !tvalid_q || m_axis_tready_i;
            ECHO_DRAIN, RESULT: s_ready = 1'b0;
            default:            s_ready = 1'b1;
        endcase
    end

    assign s_axis_tready_o = s_ready;
    assign busy_o          = (state_q != HDR_OP);
    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign bad_opcode_o    = bad_q;

    always_comb begin
        opc_d    = opc_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        lane_d   = lane_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q && !m_axis_tready_i;
        bad_d    = 1'b0;
        ser_load = 1'b0;
        ser_take = 1'b0;
        // Little-endian lane insert; lane 0 starts a fresh operand.
        opnd_n = (lane_q == '0) ? '0 : opnd_q;
        for (int b = 0; b < ACC_BYTES; b++) begin
            if (lane_q == LANE_W'(b)) opnd_n[b*8 +: 8] = s_axis_tdata_i;
        end
        case (state_q)
            HDR_OP:     if (in_fire) opc_d = s_axis_tdata_i;
            HDR_LEN_LO: if (in_fire) len_lo_d = s_axis_tdata_i;
            HDR_LEN_HI: begin
                if (in_fire) begin
                    rem_d    = pay_cnt;
                    lane_d   = '0;
                    opnd_d   = '0;
                    bad_d    = !is_add && !is_echo;
                    ser_load = is_add && (pay_cnt == '0);
                end
            end
            PAYLOAD_ADD: begin
                if (in_fire) begin
                    rem_d  = rem_q - 16'd1;
                    lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
                    opnd_d = opnd_n;
                    // Full word or trailing partial word folds in now.
                    if (lane_q == LANE_LAST || last_pay) begin
                        acc_d  = acc_q + opnd_n;
                        opnd_d = '0;
                    end
                    ser_load = last_pay;
                end
            end
            PAYLOAD_ECHO: begin
                if (in_fire) begin
                    rem_d    = rem_q - 16'd1;
                    tdata_d  = s_axis_tdata_i;
                    tvalid_d = 1'b1;
                end
            end
            RESULT: begin
                if (ser_more && (!tvalid_q || m_axis_tready_i)) begin
                    tdata_d  = ser_byte;
                    tvalid_d = 1'b1;
                    ser_take = 1'b1;
                end
                if (!ser_more && out_fire) acc_d = '0;
            end
            DISCARD: if (in_fire) rem_d = rem_q - 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            opc_q    <= '0;
            len_lo_q <= '0;
            rem_q    <= '0;
            lane_q   <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            opc_q    <= opc_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            lane_q   <= lane_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            bad_q    <= bad_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_packet_engine.sv
// Directed bench for uart_alu_packet_engine.
// Drives packets byte by byte and compares collected response bytes.
module tb_uart_alu_packet_engine;

    logic       clk;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       busy;
    logic       bad;

    int n_vec = 0;
    int n_err = 0;
    int n_bad = 0;
    int mode  = 0;
    int ncyc  = 0;

    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [7:0] rxq[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    uart_alu_packet_engine dut (
        .clk_i           (clk),
        .reset_i         (rst),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .busy_o          (busy),
        .bad_opcode_o    (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sink ready: always high, or high one cycle in three.
    always @(negedge clk) begin
        ncyc++;
        m_tready = (mode == 0) ? 1'b1 : ((ncyc % 3) == 0);
    end

    always @(posedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {24'h0, m_tdata}, {24'h0, prev_data});
            if (m_tvalid && m_tready) rxq.push_back(m_tdata);
            if (bad) n_bad++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int   n     = 0;
        logic fired = 1'b0;
        @(negedge clk);
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!fired && n < 200) begin
            @(posedge clk);
            fired = s_tready;
            n++;
        end
        if (!fired) chk("in_stall", 32'd0, 32'd1);
    endtask

    task automatic send_pkt();
        foreach (txq[i]) send_byte(txq[i]);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic expect_out(input string tag);
        int n = 0;
        while ((rxq.size() < expq.size() || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_tmo"}, {31'h0, n < 500}, 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_cnt"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, rxq[i]}, {24'h0, expq[i]});
        chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
        rxq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sready", {31'h0, s_tready}, 32'd1);
        chk("rst_mvalid", {31'h0, m_tvalid}, 32'd0);
        chk("rst_mdata", {24'h0, m_tdata}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_bad", {31'h0, bad}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 5 + 10 with first-byte latency check
        txq  = '{8'h01, 8'h00, 8'h0C, 8'h00,
                 8'h05, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
        expq = '{8'h0F, 8'h00, 8'h00, 8'h00};
        send_pkt();
        chk("lat_v0", {31'h0, m_tvalid}, 32'd0);
        @(negedge clk);
        chk("lat_v1", {31'h0, m_tvalid}, 32'd1);
        chk("lat_d1", {24'h0, m_tdata}, 32'h0F);
        expect_out("add1");

        txq  = '{8'h01, 8'h00, 8'h0C, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        expq = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt();
        expect_out("wrap");

        mode = 1;
        txq  = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt();
        expect_out("echo");
        mode = 0;

        n_bad = 0;
        txq  = '{8'h7F, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        expq = '{};
        send_pkt();
        expect_out("drop");
        chk("bad_pulses", n_bad, 32'd1);

        txq  = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        expq = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_pkt();
        expect_out("after_drop");

        txq  = '{8'h01, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        expq = '{8'h01, 8'h02, 8'h03, 8'h00};
        send_pkt();
        expect_out("partial");

        txq  = '{8'h01, 8'h00, 8'h03, 8'h00};
        expq = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt();
        expect_out("short");

        txq  = '{8'hEC, 8'h00, 8'h04, 8'h00};
        expq = '{};
        send_pkt();
        expect_out("echo0");

        // Abandon an ADD midway; the next packet must start clean.
        txq = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h06};
        send_pkt();
        chk("mid_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'd0);
        chk("mid_rst_rdy", {31'h0, s_tready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        txq  = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00};
        expq = '{8'h09, 8'h00, 8'h00, 8'h00};
        send_pkt();
        expect_out("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
